// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Detects load-use hazards, flushes on taken branches and sequences
// multi-cycle multiply/divide operations with a timeout abort.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_is_md,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic        ex_branch_taken,
    input  logic        md_done,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        md_start,
    output logic        md_error,
    output logic [15:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Last wait-counter value before the operation is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MD_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       md_seen_q, md_seen_d;   // md result delivered, ID instr may advance
    logic       timeout_hit;
    logic       load_use;

    // Load-use hazard: EX holds a load whose destination the ID instruction reads.
    always_comb begin
        load_use = idex_memread && (idex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == idex_rd)));
    end

    // Next-state logic and same-cycle pipeline control outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; an unassigned path would infer a latch.
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        md_seen_d   = md_seen_q;
        timeout_hit = 1'b0;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        // Wrong-path instructions in IF/ID are squashed; the
                        // front end keeps fetching from the branch target.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        md_seen_d   = 1'b0;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_is_md && !md_seen_q) begin
                        md_start    = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        wait_cnt_d  = 8'd0;
                        state_d     = MD_WAIT;
                    end else begin
                        // Advancing cycle: the completed md instruction leaves ID.
                        md_seen_d = 1'b0;
                    end
                end
                MD_WAIT: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (md_done) begin
                        md_seen_d = 1'b1;
                        state_d   = RUN;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = RUN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, wait counter and completion latch registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            md_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            md_seen_q  <= md_seen_d;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_error <= 1'b0;
        end else if (timeout_hit) begin
            md_error <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed stimulus, a cycle-level
// behavioural model checked every cycle, plus hand-computed spot checks.
module tb_hazard_ctrl;

    localparam int T = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, idex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_is_md;
    logic        idex_memread, ex_branch_taken, md_done;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_error;
    logic [15:0] stall_count;

    int total  = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    hazard_ctrl #(.MD_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_md(id_is_md), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ex_branch_taken(ex_branch_taken), .md_done(md_done),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_start(md_start), .md_error(md_error),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The model thinks in terms of "is an md operation outstanding, how many
    // wait cycles has it used, has its result arrived" rather than states.
    bit m_busy = 0, m_result_in = 0, m_err = 0;
    int m_waited = 0, m_stalls = 0;

    always @(negedge clk) begin
        bit hz, stall, start, squash;
        bit e_pc, e_ifw, e_fl, e_bub, e_st;
        hz = idex_memread && idex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
        squash = !rst && !m_busy && ex_branch_taken;
        start  = !rst && !m_busy && !ex_branch_taken && !hz && id_is_md && !m_result_in;
        stall  = !rst && (m_busy || (!ex_branch_taken && hz) || start);
        e_pc = !stall; e_ifw = !stall; e_fl = squash;
        e_bub = stall || squash; e_st = start;
        if (chk_en) begin
            check("pc_write",    pc_write,    e_pc);
            check("ifid_write",  ifid_write,  e_ifw);
            check("ifid_flush",  ifid_flush,  e_fl);
            check("idex_bubble", idex_bubble, e_bub);
            check("md_start",    md_start,    e_st);
            check("md_error",    md_error,    m_err);
            check("stall_count", stall_count, m_stalls);
        end
        // advance model to the values after the coming rising edge
        if (rst) begin
            m_busy = 0; m_result_in = 0; m_err = 0; m_waited = 0; m_stalls = 0;
        end else begin
            if (stall && m_stalls < 65535) m_stalls++;
            if (m_busy) begin
                if (md_done) begin m_busy = 0; m_result_in = 1; end
                else if (m_waited + 1 == T) begin m_busy = 0; m_err = 1; end
                else m_waited++;
            end else if (start) begin
                m_busy = 1; m_waited = 0;
            end else if (!stall) begin
                m_result_in = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_md = 0;
        idex_memread = 0; idex_rd = 0; ex_branch_taken = 0; md_done = 0;
    endtask

    initial begin
        int starts;
        rst = 1; idle();
        tick(); chk_en = 1; tick();
        #1 check("rst_pc_write", pc_write, 1);
        check("rst_bubble", idex_bubble, 0);
        rst = 0; tick();
        check("reset_stall_count", stall_count, 0);
        check("reset_md_error", md_error, 0);

        // load-use through rs2
        idex_memread = 1; idex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        #1 check("lu_pc_write", pc_write, 0);
        check("lu_bubble", idex_bubble, 1);
        tick(); idle(); #1;
        check("lu_stall_count", stall_count, 1);
        check("lu_one_cycle", pc_write, 1);

        // rd = x0 never hazards; unused rs2 never hazards
        idex_memread = 1; idex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
        #1 check("lu_x0_pc_write", pc_write, 1);
        tick();
        idex_rd = 5; id_rs2 = 5; id_uses_rs2 = 0; id_rs1 = 3; id_uses_rs1 = 1;
        #1 check("lu_unused_pc_write", pc_write, 1);
        check("lu_unused_ifid_write", ifid_write, 1);
        tick();
        // load-use through rs1
        id_rs1 = 5;
        #1 check("lu_rs1_pc_write", pc_write, 0);
        tick(); idle(); tick();
        check("lu_rs1_stall_count", stall_count, 2);

        // load-use together with taken branch: branch wins
        idex_memread = 1; idex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; ex_branch_taken = 1;
        id_is_md = 1;
        #1 check("br_flush", ifid_flush, 1);
        check("br_bubble", idex_bubble, 1);
        check("br_pc_write", pc_write, 1);
        check("br_md_start", md_start, 0);
        tick(); idle(); #1;
        check("br_stall_count", stall_count, 2);

        // md operation, done 4 cycles after start, ID instr held with id_is_md=1
        starts = 0;
        id_is_md = 1;
        for (int c = 0; c <= 5; c++) begin
            md_done = (c == 4);
            if (c == 2) ex_branch_taken = 1;   // ignored while waiting
            else ex_branch_taken = 0;
            #1 starts += int'(md_start);
            if (c == 5) check("md_advance_pc_write", pc_write, 1);
            tick();
        end
        idle(); #1;
        check("md_start_pulses", starts, 1);
        check("md_stall_count", stall_count, 7);

        // md_done in RUN is ignored
        md_done = 1;
        #1 check("done_in_run_pc_write", pc_write, 1);
        tick(); idle();

        // timeout: done never arrives
        id_is_md = 1; tick(); id_is_md = 0;
        for (int c = 1; c < T; c++) tick();
        #1 check("pre_timeout_pc_write", pc_write, 0);
        check("pre_timeout_md_error", md_error, 0);
        tick();
        check("timeout_pc_write", pc_write, 1);
        check("timeout_md_error", md_error, 1);
        check("timeout_stall_count", stall_count, 7 + T + 1);
        for (int c = 0; c < 3; c++) tick();
        check("md_error_sticky", md_error, 1);

        // reset in the middle of a wait
        id_is_md = 1; tick(); id_is_md = 0; tick(); tick();
        rst = 1;
        #1 check("rst_mid_pc_write", pc_write, 1);
        check("rst_mid_md_start", md_start, 0);
        tick(); rst = 0; #1;
        check("rst_mid_run", pc_write, 1);
        check("rst_mid_md_error", md_error, 0);
        check("rst_mid_stall_count", stall_count, 0);

        // md_done on the timeout cycle: completion wins
        id_is_md = 1;
        for (int c = 0; c <= T; c++) begin
            md_done = (c == T);
            tick();
        end
        md_done = 0; #1;
        check("race_md_error", md_error, 0);
        check("race_no_restart", md_start, 0);
        check("race_pc_write", pc_write, 1);
        tick(); idle(); tick();
        check("race_stall_count", stall_count, T + 1);

        chk_en = 0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
